demux_1in_4out_tdm: RTL and testbench

DEMUX_1IN_4OUT_TDM -- requirements
Module: demux_1in_4out_tdm

---
 rtl/demux_tdm_pkg.sv | 18 +
 rtl/tdm_slot_counter.sv | 40 ++++
 rtl/demux_1in_4out_tdm.sv | 169 ++++++++++++++++
 tb/tb_demux_1in_4out_tdm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_tdm_pkg.sv
// ----------------------------------------------------------------------------
// demux_tdm_pkg
// Shared definitions for the 1-to-4 TDM demultiplexer:
//   NUM_CH  - number of time slots (channels) per frame
//   SEL_W   - width of the slot index
//   state_t - frame-alignment FSM states (HUNT, LOCKED)
// ----------------------------------------------------------------------------
package demux_tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// ----------------------------------------------------------------------------
// tdm_slot_counter
// Slot index counter for the TDM demultiplexer. It wraps modulo 2**SEL_W.
// Priority: clr > load_one > en.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (count -> 0)
//   clr      - synchronous clear to slot 0
//   load_one - synchronous load of slot 1 (slot 0 was just filled by a sync)
//   en       - advance to the next slot
//   count    - current slot index (registered)
// ----------------------------------------------------------------------------
module tdm_slot_counter
    import demux_tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_one,
    input  logic             en,
    output logic [SEL_W-1:0] count
);

    logic [SEL_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load_one) begin
            count_reg <= SEL_W'(1);
        end else if (en) begin
            count_reg <= count_reg + SEL_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/demux_1in_4out_tdm.sv
// ----------------------------------------------------------------------------
// demux_1in_4out_tdm
// Collects a time-multiplexed sample stream into 4-channel frames. The slot-0
// sample is marked by sync. A complete frame is presented on Q together with
// a one-cycle frame_valid pulse.
// Parameters:
//   W          - bits per channel sample
//   SYNC_CHECK - 1: sync must accompany every slot-0 sample. A missing sync
//                drops lock. 0: after the first lock the block free-runs.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   d           - sample stream (qualified by en)
//   en          - sample strobe
//   sync        - marks the en-cycle carrying slot 0
//   err_clr     - synchronous clear of sync_err
//   Q           - last complete frame; channel k at Q[k*W +: W]
//   sel         - slot the next en sample will fill
//   frame_valid - one-cycle pulse when Q has just been loaded
//   locked      - FSM is in LOCKED
//   sync_err    - sticky framing-error flag
// ----------------------------------------------------------------------------
module demux_1in_4out_tdm
    import demux_tdm_pkg::*;
#(
    parameter int          W          = 1,
    parameter int unsigned SYNC_CHECK = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        d,
    input  logic                en,
    input  logic                sync,
    input  logic                err_clr,
    output logic [NUM_CH*W-1:0] Q,
    output logic [SEL_W-1:0]    sel,
    output logic                frame_valid,
    output logic                locked,
    output logic                sync_err
);

    state_t              state_reg, state_next;
    logic [W-1:0]        staging_reg [0:NUM_CH-2];
    logic [NUM_CH*W-1:0] q_reg;
    logic [NUM_CH*W-1:0] frame_word;
    logic                fv_reg;
    logic                err_reg;
    logic [SEL_W-1:0]    sel_cur;

    logic                cnt_clr;
    logic                cnt_load;
    logic                cnt_inc;
    logic                err_event;
    logic                stage_wr;
    logic                stage_flush;
    logic [SEL_W-1:0]    stage_idx;
    logic                frame_done;

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load_one (cnt_load),
        .en       (cnt_inc),
        .count    (sel_cur)
    );

    // Next-state and datapath control. Nothing moves unless en is high.
    always_comb begin
        state_next  = state_reg;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        err_event   = 1'b0;
        stage_wr    = 1'b0;
        stage_flush = 1'b0;
        stage_idx   = sel_cur;
        frame_done  = 1'b0;
        if (en) begin
            case (state_reg)
                HUNT: begin
                    if (sync) begin
                        stage_wr   = 1'b1;
                        stage_idx  = '0;
                        cnt_load   = 1'b1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync && sel_cur != '0) begin
                        // Early sync: drop the fragment and restart the frame at this sample.
                        err_event   = 1'b1;
                        stage_flush = 1'b1;
                        stage_wr    = 1'b1;
                        stage_idx   = '0;
                        cnt_load    = 1'b1;
                    end else if (!sync && sel_cur == '0 && SYNC_CHECK != 0) begin
                        // Missing sync at slot 0: discard the sample and re-hunt.
                        err_event  = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = HUNT;
                    end else begin
                        cnt_inc = 1'b1;
                        // The last slot goes straight into Q and is never staged.
                        if (sel_cur == SEL_W'(NUM_CH - 1)) begin
                            frame_done = 1'b1;
                        end else begin
                            stage_wr = 1'b1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // The completed frame is the staged slots plus the live last-slot sample.
    generate
        for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_frame
            assign frame_word[gi*W +: W] = staging_reg[gi];
        end
    endgenerate
    assign frame_word[(NUM_CH-1)*W +: W] = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                staging_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                if (stage_flush) begin
                    staging_reg[i] <= '0;
                end
                if (stage_wr && stage_idx == SEL_W'(i)) begin
                    staging_reg[i] <= d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            q_reg     <= '0;
            fv_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fv_reg    <= frame_done;
            if (frame_done) begin
                q_reg <= frame_word;
            end
            // A new error takes priority over a clear in the same cycle.
            if (err_event) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign Q           = q_reg;
    assign sel         = sel_cur;
    assign frame_valid = fv_reg;
    assign locked      = (state_reg == LOCKED);
    assign sync_err    = err_reg;

endmodule

// File: tb/tb_demux_1in_4out_tdm.sv
// ----------------------------------------------------------------------------
// tb_demux_1in_4out_tdm
// Drives two instances with identical stimulus (W=4): dut with SYNC_CHECK=1
// and dut_nc with SYNC_CHECK=0. Directed scenarios use fixed expected frames.
// A random phase compares both instances against a frame-collecting model.
// ----------------------------------------------------------------------------
module tb_demux_1in_4out_tdm;

    logic        clk;
    logic        rst_n;
    logic [3:0]  d;
    logic        en;
    logic        sync;
    logic        err_clr;

    logic [15:0] q0, q1;
    logic [1:0]  sel0, sel1;
    logic        fv0, fv1, lk0, lk1, se0, se1;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1in_4out_tdm #(.W(4), .SYNC_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .sync(sync), .err_clr(err_clr),
        .Q(q0), .sel(sel0), .frame_valid(fv0), .locked(lk0), .sync_err(se0)
    );

    demux_1in_4out_tdm #(.W(4), .SYNC_CHECK(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .sync(sync), .err_clr(err_clr),
        .Q(q1), .sel(sel1), .frame_valid(fv1), .locked(lk1), .sync_err(se1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: for each instance, the samples collected so far for the
    // current frame, a lock flag, the sticky error, the last frame and a pulse.
    // Index 0 models sync checking on, index 1 models sync checking off.
    logic [3:0]  m_buf [2][4];
    int          m_n   [2];
    bit          m_lock[2];
    bit          m_err [2];
    logic [15:0] m_q   [2];
    bit          m_fv  [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_n[m] = 0; m_lock[m] = 0; m_err[m] = 0; m_q[m] = '0; m_fv[m] = 0;
            for (int k = 0; k < 4; k++) m_buf[m][k] = '0;
        end
    endtask

    task automatic model_clock();
        bit ev;
        bit check_sync;
        for (int m = 0; m < 2; m++) begin
            ev = 0;
            check_sync = (m == 0);
            m_fv[m] = 0;
            if (en) begin
                if (!m_lock[m]) begin
                    if (sync) begin
                        m_buf[m][0] = d; m_n[m] = 1; m_lock[m] = 1;
                    end
                end else if (sync && m_n[m] != 0) begin
                    ev = 1; m_buf[m][0] = d; m_n[m] = 1;
                end else if (!sync && m_n[m] == 0 && check_sync) begin
                    ev = 1; m_lock[m] = 0;
                end else begin
                    m_buf[m][m_n[m]] = d;
                    m_n[m] = m_n[m] + 1;
                    if (m_n[m] == 4) begin
                        m_q[m]  = {m_buf[m][3], m_buf[m][2], m_buf[m][1], m_buf[m][0]};
                        m_fv[m] = 1;
                        m_n[m]  = 0;
                    end
                end
            end
            if (ev) m_err[m] = 1;
            else if (err_clr) m_err[m] = 0;
        end
    endtask

    // One clock of stimulus. It updates the model and returns 1 ns after the edge.
    task automatic step(input bit e, input bit s, input logic [3:0] dv, input bit c);
        @(negedge clk);
        en = e; sync = s; d = dv; err_clr = c;
        @(posedge clk);
        model_clock();
        #1;
        $display("txn t=%0t en=%0b sync=%0b d=%h clr=%0b | Q=%h sel=%0d fv=%0b lk=%0b err=%0b | nc: Q=%h sel=%0d fv=%0b lk=%0b err=%0b",
                 $time, e, s, dv, c, q0, sel0, fv0, lk0, se0, q1, sel1, fv1, lk1, se1);
    endtask

    // Asserts reset between edges and returns 2 ns later, still inside the reset window.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 0; sync = 0; d = '0; err_clr = 0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; sync = 0; d = '0; err_clr = 0;
        model_reset();
        #2;
        n_checks++; if (q0 !== 16'h0000) begin n_fail++; $display("FAIL reset_q: got %h want 0000", q0); end
        n_checks++; if (sel0 !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel0); end
        n_checks++; if ({fv0, lk0, se0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got fv/lk/err=%b want 000", {fv0, lk0, se0}); end
        @(posedge clk); #1;
        n_checks++; if (lk0 !== 1'b0 || sel0 !== 2'd0) begin n_fail++; $display("FAIL reset_hold: got lk=%0b sel=%0d want 0/0", lk0, sel0); end
        release_reset();
        // Unsynced samples in HUNT are ignored.
        step(1, 0, 4'h7, 0);
        n_checks++; if (lk0 !== 1'b0 || sel0 !== 2'd0) begin n_fail++; $display("FAIL hunt_ignore: got lk=%0b sel=%0d want 0/0", lk0, sel0); end
    endtask

    task automatic test_clean();
        step(1, 1, 4'hA, 0);
        n_checks++; if (lk0 !== 1'b1 || sel0 !== 2'd1) begin n_fail++; $display("FAIL clean_lock: got lk=%0b sel=%0d want 1/1", lk0, sel0); end
        step(1, 0, 4'hB, 0);
        step(1, 0, 4'hC, 0);
        n_checks++; if (fv0 !== 1'b0 || q0 !== 16'h0000) begin n_fail++; $display("FAIL clean_early_fv: got fv=%0b Q=%h want 0/0000", fv0, q0); end
        step(1, 0, 4'hD, 0);
        n_checks++; if (q0 !== 16'hDCBA) begin n_fail++; $display("FAIL clean_q: got %h want DCBA", q0); end
        n_checks++; if ({fv0, lk0, se0, sel0} !== 5'b11000) begin n_fail++; $display("FAIL clean_flags: got fv/lk/err/sel=%b want 11000", {fv0, lk0, se0, sel0}); end
        step(0, 0, 4'h0, 0);
        n_checks++; if (fv0 !== 1'b0 || q0 !== 16'hDCBA) begin n_fail++; $display("FAIL clean_pulse_end: got fv=%0b Q=%h want 0/DCBA", fv0, q0); end
    endtask

    task automatic test_gapped();
        bit         ge [11];
        bit         gs [11];
        logic [3:0] gd [11];
        int         pulses;
        ge = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        gs = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        gd = '{4'hA, 4'hF, 4'h3, 4'hB, 4'h0, 4'h7, 4'hC, 4'h0, 4'hD, 4'h0, 4'h0};
        apply_reset();
        release_reset();
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            step(ge[i], gs[i], gd[i], 0);
            if (fv0) pulses++;
            if (i == 2) begin
                n_checks++; if (sel0 !== 2'd1) begin n_fail++; $display("FAIL gap_sel1: got %0d want 1", sel0); end
            end
            if (i == 5) begin
                n_checks++; if (sel0 !== 2'd2) begin n_fail++; $display("FAIL gap_sel2: got %0d want 2", sel0); end
            end
            if (i == 7) begin
                n_checks++; if (sel0 !== 2'd3) begin n_fail++; $display("FAIL gap_sel3: got %0d want 3", sel0); end
            end
        end
        n_checks++; if (q0 !== 16'hDCBA) begin n_fail++; $display("FAIL gap_q: got %h want DCBA", q0); end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_early_sync();
        int pulses;
        apply_reset();
        release_reset();
        pulses = 0;
        step(1, 1, 4'hA, 0); if (fv0) pulses++;
        step(1, 0, 4'hB, 0); if (fv0) pulses++;
        step(1, 1, 4'h5, 0); if (fv0) pulses++;
        n_checks++; if (se0 !== 1'b1 || sel0 !== 2'd1) begin n_fail++; $display("FAIL early_err: got err=%0b sel=%0d want 1/1", se0, sel0); end
        step(1, 0, 4'h6, 0); if (fv0) pulses++;
        step(1, 0, 4'h7, 0); if (fv0) pulses++;
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL early_no_fv: got %0d pulses want 0", pulses); end
        step(1, 0, 4'h8, 0);
        n_checks++; if (q0 !== 16'h8765 || fv0 !== 1'b1) begin n_fail++; $display("FAIL early_q: got Q=%h fv=%0b want 8765/1", q0, fv0); end
        n_checks++; if (se0 !== 1'b1) begin n_fail++; $display("FAIL early_sticky: got %0b want 1", se0); end
    endtask

    task automatic test_missing_sync();
        apply_reset();
        release_reset();
        step(1, 1, 4'hA, 0);
        step(1, 0, 4'hB, 0);
        step(1, 0, 4'hC, 0);
        step(1, 0, 4'hD, 0);
        n_checks++; if (q0 !== 16'hDCBA || q1 !== 16'hDCBA) begin n_fail++; $display("FAIL miss_first: got Q=%h nc Q=%h want DCBA/DCBA", q0, q1); end
        step(1, 0, 4'h9, 0);
        n_checks++; if ({lk0, sel0, se0} !== 4'b0001) begin n_fail++; $display("FAIL miss_check: got lk/sel/err=%b want 0001", {lk0, sel0, se0}); end
        n_checks++; if ({lk1, sel1, se1} !== 4'b1010) begin n_fail++; $display("FAIL miss_nocheck: got lk/sel/err=%b want 1010", {lk1, sel1, se1}); end
        step(1, 0, 4'h1, 0);
        step(1, 0, 4'h2, 0);
        step(1, 0, 4'h3, 0);
        n_checks++; if (q0 !== 16'hDCBA || lk0 !== 1'b0) begin n_fail++; $display("FAIL miss_hold: got Q=%h lk=%0b want DCBA/0", q0, lk0); end
        n_checks++; if (q1 !== 16'h3219 || fv1 !== 1'b1 || se1 !== 1'b0) begin n_fail++; $display("FAIL miss_freerun: got Q=%h fv=%0b err=%0b want 3219/1/0", q1, fv1, se1); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        step(1, 1, 4'hA, 0);
        step(1, 0, 4'hB, 0);
        step(1, 0, 4'hC, 0);
        step(1, 0, 4'hD, 0);
        step(1, 1, 4'h5, 0);
        step(1, 0, 4'h6, 0);
        apply_reset();
        n_checks++; if (q0 !== 16'h0000 || sel0 !== 2'd0 || lk0 !== 1'b0) begin n_fail++; $display("FAIL midrst_now: got Q=%h sel=%0d lk=%0b want 0000/0/0", q0, sel0, lk0); end
        release_reset();
        step(1, 0, 4'h7, 0);
        step(1, 0, 4'h7, 0);
        n_checks++; if (lk0 !== 1'b0 || sel0 !== 2'd0) begin n_fail++; $display("FAIL midrst_hunt: got lk=%0b sel=%0d want 0/0", lk0, sel0); end
        step(1, 1, 4'h1, 0);
        step(1, 0, 4'h2, 0);
        step(1, 0, 4'h3, 0);
        step(1, 0, 4'h4, 0);
        n_checks++; if (q0 !== 16'h4321 || fv0 !== 1'b1) begin n_fail++; $display("FAIL midrst_frame: got Q=%h fv=%0b want 4321/1", q0, fv0); end
    endtask

    task automatic test_err_clr();
        apply_reset();
        release_reset();
        step(1, 1, 4'h1, 0);
        step(1, 0, 4'h2, 0);
        step(1, 1, 4'h3, 0);
        n_checks++; if (se0 !== 1'b1) begin n_fail++; $display("FAIL clr_setup: got err=%0b want 1", se0); end
        step(0, 0, 4'h0, 1);
        n_checks++; if (se0 !== 1'b0) begin n_fail++; $display("FAIL clr_pulse: got err=%0b want 0", se0); end
        step(1, 1, 4'h5, 1);
        n_checks++; if (se0 !== 1'b1) begin n_fail++; $display("FAIL clr_coincident: got err=%0b want 1", se0); end
    endtask

    task automatic test_random();
        bit         e, s, c;
        logic [3:0] dv;
        apply_reset();
        release_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            // Favour sync near frame boundaries so complete frames occur often.
            if (m_n[0] == 0) s = ($urandom_range(0, 3) != 0);
            else             s = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 15) == 0);
            dv = 4'($urandom);
            step(e, s, dv, c);
            n_checks++;
            if ({q0, sel0, fv0, lk0, se0} !== {m_q[0], 2'(m_lock[0] ? m_n[0] : 0), m_fv[0], m_lock[0], m_err[0]}) begin
                n_fail++;
                $display("FAIL rand_check[%0d]: got Q=%h sel=%0d fv=%0b lk=%0b err=%0b want Q=%h sel=%0d fv=%0b lk=%0b err=%0b",
                         i, q0, sel0, fv0, lk0, se0, m_q[0], m_n[0], m_fv[0], m_lock[0], m_err[0]);
            end
            n_checks++;
            if ({q1, sel1, fv1, lk1, se1} !== {m_q[1], 2'(m_lock[1] ? m_n[1] : 0), m_fv[1], m_lock[1], m_err[1]}) begin
                n_fail++;
                $display("FAIL rand_nocheck[%0d]: got Q=%h sel=%0d fv=%0b lk=%0b err=%0b want Q=%h sel=%0d fv=%0b lk=%0b err=%0b",
                         i, q1, sel1, fv1, lk1, se1, m_q[1], m_n[1], m_fv[1], m_lock[1], m_err[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_gapped();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        test_err_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
